// File: rtl/op_request_encoder.sv
// Round-robin encoder: collects operation requests and issues one 3-bit opcode
// at a time under a valid/ready handshake. Unsupported requests are flagged and counted.
module op_request_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] Req,
  input  logic        Opcode_Ready,
  output logic [2:0]  Opcode,
  output logic        Opcode_Valid,
  output logic [7:0]  Pending,
  output logic        Busy,
  output logic        Unsupported_Err,
  output logic [3:0]  Err_Count
);
  localparam int NUM_OPS = 8;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]         state;
  logic [2:0]         last_grant;
  logic [2:0]         grant_idx;
  logic [2:0]         cand;
  logic               grant_found;
  logic               grant_en;
  logic [NUM_OPS-1:0] grant_mask;
  logic               unsup;

  // First set Pending bit at or after last_grant+1, wrapping; the 3-bit add does the mod 8.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 3'd0;
    for (int i = 1; i <= NUM_OPS; i++) begin
      cand = last_grant + 3'(i);
      if (!grant_found && Pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // In ISSUE a new grant only happens on the same edge the current opcode is accepted.
  assign grant_en   = grant_found && (state == IDLE || Opcode_Ready);
  assign grant_mask = grant_en ? (NUM_OPS'(1) << grant_idx) : '0;
  assign unsup      = |Req[11:8];
  assign Busy       = Opcode_Valid | (|Pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      Pending         <= '0;
      Opcode          <= 3'd0;
      Opcode_Valid    <= 1'b0;
      Unsupported_Err <= 1'b0;
      Err_Count       <= 4'd0;
      last_grant      <= 3'd7;
    end else begin
      Pending         <= (Pending & ~grant_mask) | Req[7:0];
      Unsupported_Err <= unsup;
      if (unsup && Err_Count != 4'hF)
        Err_Count <= Err_Count + 4'd1;
      if (grant_en) begin
        Opcode       <= grant_idx;
        last_grant   <= grant_idx;
        Opcode_Valid <= 1'b1;
        state        <= ISSUE;
      end else if (state == ISSUE && Opcode_Ready) begin
        Opcode_Valid <= 1'b0;
        state        <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_op_request_encoder.sv
// Self-checking bench for op_request_encoder: per-scenario tasks with inline
// checks plus a scoreboard of expected opcodes popped on each handshake.
module tb_op_request_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] Req;
  logic        Opcode_Ready;
  logic [2:0]  Opcode;
  logic        Opcode_Valid;
  logic [7:0]  Pending;
  logic        Busy;
  logic        Unsupported_Err;
  logic [3:0]  Err_Count;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  op_request_encoder dut (
    .clk(clk), .rst(rst), .Req(Req), .Opcode_Ready(Opcode_Ready),
    .Opcode(Opcode), .Opcode_Valid(Opcode_Valid), .Pending(Pending),
    .Busy(Busy), .Unsupported_Err(Unsupported_Err), .Err_Count(Err_Count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted opcode must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && Opcode_Valid && Opcode_Ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%0d expected=none", Opcode);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (Opcode !== e) begin
          failures++;
          $display("FAIL sb_opcode got=%0d expected=%0d", Opcode, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((Opcode_Valid || Pending != 8'h00) && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (Opcode_Valid || Pending != 8'h00) begin
      failures++;
      $display("FAIL %s_drain_timeout valid=%0b pending=%h expected idle", name, Opcode_Valid, Pending);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_sb_leftover got=%0d expected=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; Req = 12'h000; Opcode_Ready = 1'b0;
    step(); step();
    checks++;
    if ({Opcode_Valid, Opcode, Pending, Busy, Unsupported_Err, Err_Count} !== 17'h0) begin
      failures++;
      $display("FAIL reset_state valid=%0b op=%0d pend=%h busy=%0b err=%0b cnt=%0d expected all zero",
               Opcode_Valid, Opcode, Pending, Busy, Unsupported_Err, Err_Count);
    end
    rst = 1'b0; Opcode_Ready = 1'b1;
    // Ready with nothing valid must do nothing.
    step(); step();
    checks++;
    if (Opcode_Valid !== 1'b0 || Pending !== 8'h00 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready valid=%0b pend=%h busy=%0b expected 0/00/0", Opcode_Valid, Pending, Busy);
    end
  endtask

  task automatic test_single;
    Opcode_Ready = 1'b1; Req = 12'h001; exp_q.push_back(3'd0);
    step();
    Req = 12'h000;
    checks++;
    if (Pending !== 8'h01 || Opcode_Valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pending pend=%h valid=%0b expected 01/0", Pending, Opcode_Valid);
    end
    step();
    checks++;
    if (Opcode_Valid !== 1'b1 || Opcode !== 3'd0 || Pending !== 8'h00) begin
      failures++;
      $display("FAIL single_issue valid=%0b op=%0d pend=%h expected 1/0/00", Opcode_Valid, Opcode, Pending);
    end
    step();
    checks++;
    if (Opcode_Valid !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done valid=%0b busy=%0b expected 0/0", Opcode_Valid, Busy);
    end
    drain("single");
  endtask

  task automatic test_back_to_back;
    logic [2:0] seq[3];
    seq = '{3'd2, 3'd5, 3'd7};
    Opcode_Ready = 1'b1; Req = 12'h0A4;
    foreach (seq[i]) exp_q.push_back(seq[i]);
    step();
    Req = 12'h000;
    checks++;
    if (Pending !== 8'hA4) begin
      failures++;
      $display("FAIL b2b_pending got=%h expected=a4", Pending);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (Opcode_Valid !== 1'b1 || Opcode !== seq[i]) begin
        failures++;
        $display("FAIL b2b_issue%0d valid=%0b op=%0d expected 1/%0d", i, Opcode_Valid, Opcode, seq[i]);
      end
    end
    step();
    checks++;
    if (Opcode_Valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end valid=%0b expected 0", Opcode_Valid);
    end
    drain("b2b");
  endtask

  task automatic test_hold;
    Opcode_Ready = 1'b0; Req = 12'h008; exp_q.push_back(3'd3);
    step();
    Req = 12'h000;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (Opcode_Valid !== 1'b1 || Opcode !== 3'd3) begin
        failures++;
        $display("FAIL hold_cycle%0d valid=%0b op=%0d expected 1/3", i, Opcode_Valid, Opcode);
      end
    end
    Opcode_Ready = 1'b1;
    step();
    checks++;
    if (Opcode_Valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_accept valid=%0b expected 0", Opcode_Valid);
    end
    drain("hold");
  endtask

  task automatic test_fairness;
    // Last grant was 3; Req held K=8 edges gives K+1 alternating grants starting at 0.
    Opcode_Ready = 1'b1; Req = 12'h009;
    for (int i = 0; i < 9; i++) exp_q.push_back((i % 2 == 0) ? 3'd0 : 3'd3);
    repeat (8) step();
    Req = 12'h000;
    drain("fair");
  endtask

  task automatic test_unsupported;
    Opcode_Ready = 1'b1; Req = 12'h200;
    step();
    Req = 12'h000;
    checks++;
    if (Unsupported_Err !== 1'b1 || Err_Count !== 4'd1 || Pending !== 8'h00) begin
      failures++;
      $display("FAIL unsup_first err=%0b cnt=%0d pend=%h expected 1/1/00", Unsupported_Err, Err_Count, Pending);
    end
    step();
    checks++;
    if (Unsupported_Err !== 1'b0 || Opcode_Valid !== 1'b0 || Err_Count !== 4'd1) begin
      failures++;
      $display("FAIL unsup_pulse err=%0b valid=%0b cnt=%0d expected 0/0/1", Unsupported_Err, Opcode_Valid, Err_Count);
    end
    Req = 12'h200;
    repeat (20) step();
    Req = 12'h000;
    checks++;
    if (Err_Count !== 4'd15) begin
      failures++;
      $display("FAIL unsup_saturate got=%0d expected=15", Err_Count);
    end
    step();
  endtask

  task automatic test_reset_mid;
    Opcode_Ready = 1'b0; Req = 12'h0F0;
    step(); step();
    checks++;
    if (Opcode_Valid !== 1'b1 || Pending !== 8'hF0) begin
      failures++;
      $display("FAIL rstmid_setup valid=%0b pend=%h expected 1/f0", Opcode_Valid, Pending);
    end
    rst = 1'b1; Req = 12'h2FF;
    step();
    rst = 1'b0; Req = 12'h000;
    checks++;
    if (Opcode_Valid !== 1'b0 || Pending !== 8'h00 || Err_Count !== 4'd0 || Unsupported_Err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear valid=%0b pend=%h cnt=%0d err=%0b expected 0/00/0/0",
               Opcode_Valid, Pending, Err_Count, Unsupported_Err);
    end
    step();
    checks++;
    if (Pending !== 8'h00 || Unsupported_Err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_req_dropped pend=%h err=%0b expected 00/0", Pending, Unsupported_Err);
    end
    Opcode_Ready = 1'b1; Req = 12'h081;
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    step();
    Req = 12'h000;
    step();
    checks++;
    if (Opcode !== 3'd0 || Opcode_Valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_first_grant op=%0d valid=%0b expected 0/1", Opcode, Opcode_Valid);
    end
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_fairness();
    test_unsupported();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
